// File: rtl/e_pipe_feeder_if.sv
// e_pipe_feeder_if: operand stream, pipeline operand/stall lines and result stream of the E-pipe feeder
interface e_pipe_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  in_c;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic        stall;
  logic [15:0] e_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  modport master (
    output in_valid, in_a, in_b, in_c, e_in, res_ready,
    input  in_ready, a, b, c, stall, res_valid, res_data
  );
  modport slave (
    input  in_valid, in_a, in_b, in_c, e_in, res_ready,
    output in_ready, a, b, c, stall, res_valid, res_data
  );
endinterface

// File: rtl/e_pipe_feeder.sv
// e_pipe_feeder: operand FIFO, bubble insertion, shadow stage-valid tracking and stall generation for the E-pipeline; FEEDER_STATS_EN builds the saturating stall counter
module e_pipe_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  e_pipe_feeder_if.slave         bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic [2:0]    vld_q;
  logic          not_empty;
  logic          push;
  logic          pop;
  assign not_empty     = level_q != '0;
  assign bus.in_ready  = level_q != FULL;
  assign bus.stall     = vld_q[2] & ~bus.res_ready;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = ~bus.stall & not_empty;
  assign {bus.a, bus.b, bus.c} = not_empty ? mem_q[rd_ptr_q] : 24'h0;
  assign bus.res_valid = vld_q[2];
  assign bus.res_data  = bus.e_in;
  assign level         = level_q;
  // occupancy next state; a simultaneous push and pop cancel out
  always_comb level_d = (push && !pop) ? level_q + 1'b1 : (!push && pop) ? level_q - 1'b1 : level_q;
  // triple storage; contents need no reset because the head is gated by occupancy
  always_ff @(posedge clk) if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_c};
  // pointers, occupancy and the shadow valid chain that mirrors the pipeline stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (!bus.stall) vld_q <= {vld_q[1:0], not_empty};
    end
  end
`ifdef FEEDER_STATS_EN
  logic [15:0] stall_cnt_q;
  // saturating count of stalled cycles, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else if (bus.stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
  end
  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0;
`endif
endmodule

// File: tb/tb_e_pipe_feeder.sv
// tb_e_pipe_feeder: directed vectors and scoreboard for e_pipe_feeder driving a behavioural 3-stage E-pipeline
module tb_e_pipe_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] level;
  logic [15:0] stall_cycles;
  int checks = 0;
  int errors = 0;
  int got = 0;
  logic [15:0] exp_q[$];
  logic [2:0][23:0] st_q;
  e_pipe_feeder_if bus ();
  e_pipe_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] eval(input logic [23:0] t);
    return 16'(5 * int'(t[23:16]) + 5 * int'(t[15:8]) - 4 * int'(t[7:0]) + 3 * 768);
  endfunction
  function automatic logic [23:0] trip(input int i);
    return {8'(i * 17 + 3), 8'(i * 29 + 5), 8'(250 - i * 23)};
  endfunction
  // behavioural pipeline: three stage registers sharing rst and stall, combinational E from stage 3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= '0;
    else if (!bus.stall) st_q <= {st_q[1:0], bus.a, bus.b, bus.c};
  end
  assign bus.e_in = eval(st_q[2]);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // scoreboard: record accepted triples, compare delivered results in push order
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (bus.res_valid && bus.res_ready) begin
        chk("sb_expected_present", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("sb_order", bus.res_data, exp_q.pop_front());
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(eval({bus.in_a, bus.in_b, bus.in_c}));
    end
  end
  task automatic cyc_drive(input logic iv, input logic [23:0] t, input logic rr);
    @(negedge clk);
    bus.in_valid = iv;
    {bus.in_a, bus.in_b, bus.in_c} = t;
    bus.res_ready = rr;
    #1;
  endtask
  typedef struct {
    logic        iv;
    logic [23:0] t;
    logic        rr;
    logic [2:0]  lvl;
    logic [23:0] hd;
    logic        rv;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl[13];
  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int acc;
    int base;
    int n;
    tbl[0]  = '{1'b1, 24'h010203, 1'b1, 3'd0, 24'h000000, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 24'h000000, 1'b1, 3'd1, 24'h010203, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 24'h0a141e, 1'b1, 3'd0, 24'h000000, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 24'hffffff, 1'b1, 3'd1, 24'h0a141e, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 24'h000000, 1'b1, 3'd1, 24'hffffff, 1'b1, 16'd2307};
    tbl[5]  = '{1'b0, 24'h000000, 1'b0, 3'd0, 24'h000000, 1'b0, 16'd0};
    tbl[6]  = '{1'b0, 24'h000000, 1'b1, 3'd0, 24'h000000, 1'b1, 16'd2334};
    tbl[7]  = '{1'b1, 24'h0000ff, 1'b1, 3'd0, 24'h000000, 1'b1, 16'd3834};
    tbl[8]  = '{1'b0, 24'h000000, 1'b1, 3'd1, 24'h0000ff, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 24'h000000, 1'b0, 3'd0, 24'h000000, 1'b0, 16'd0};
    tbl[10] = '{1'b0, 24'h000000, 1'b1, 3'd0, 24'h000000, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 24'h000000, 1'b1, 3'd0, 24'h000000, 1'b1, 16'd1284};
    tbl[12] = '{1'b0, 24'h000000, 1'b1, 3'd0, 24'h000000, 1'b0, 16'd0};
    bus.in_valid = 1'b0;
    {bus.in_a, bus.in_b, bus.in_c} = 24'h0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_head", {8'h0, bus.a, bus.b, bus.c}, 0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1'b1;
    // sparse stream: pushes in cycles 0, 2, 3, 7
    foreach (tbl[i]) begin
      cyc_drive(tbl[i].iv, tbl[i].t, tbl[i].rr);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_head", i), {8'h0, bus.a, bus.b, bus.c}, {8'h0, tbl[i].hd});
      chk($sformatf("vec%0d_res_valid", i), 32'(bus.res_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 0);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 1);
      if (tbl[i].rv) chk($sformatf("vec%0d_res_data", i), 32'(bus.res_data), 32'(tbl[i].rd));
    end
    // backpressure: ten back-to-back triples with res_ready low
    acc = 0;
    base = got;
    for (int i = 0; i < 12; i++) begin
      cyc_drive(acc < 10, trip(acc), 1'b0);
      chk($sformatf("bp_stall_c%0d", i), 32'(bus.stall), 32'(i >= 4));
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chk("bp_accepted", acc, 7);
    chk("bp_level", 32'(level), 4);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_res_hold", 32'(bus.res_data), 32'(eval(trip(0))));
    chk("bp_no_delivery", got - base, 0);
    for (int i = 0; i < 30 && got - base < 10; i++) begin
      cyc_drive(acc < 10, trip(acc), 1'b1);
      if (i < 10) chk($sformatf("drain_rv_c%0d", i), 32'(bus.res_valid), 1);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    chk("drain_count", got - base, 10);
    chk("drain_sb_empty", exp_q.size(), 0);
    repeat (4) cyc_drive(1'b0, 24'h0, 1'b1);
    // simultaneous push and pop at level 2
    for (int i = 0; i < 5; i++) cyc_drive(1'b1, trip(20 + i), 1'b0);
    chk("pp_level_pre", 32'(level), 1);
    chk("pp_stall_pre", 32'(bus.stall), 1);
    cyc_drive(1'b1, trip(25), 1'b1);
    chk("pp_level_c5", 32'(level), 2);
    chk("pp_stall_c5", 32'(bus.stall), 0);
    chk("pp_head_c5", {8'h0, bus.a, bus.b, bus.c}, {8'h0, trip(23)});
    cyc_drive(1'b0, 24'h0, 1'b1);
    chk("pp_level_c6", 32'(level), 2);
    chk("pp_head_c6", {8'h0, bus.a, bus.b, bus.c}, {8'h0, trip(24)});
    repeat (8) cyc_drive(1'b0, 24'h0, 1'b1);
    // full FIFO refuses a push even while popping
    for (int i = 0; i < 8; i++) cyc_drive(1'b1, trip(30 + i), 1'b0);
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    cyc_drive(1'b1, trip(37), 1'b1);
    chk("full_pop_level", 32'(level), 4);
    chk("full_pop_in_ready", 32'(bus.in_ready), 0);
    chk("full_pop_stall", 32'(bus.stall), 0);
    cyc_drive(1'b1, trip(37), 1'b1);
    chk("after_pop_level", 32'(level), 3);
    chk("after_pop_in_ready", 32'(bus.in_ready), 1);
    repeat (12) cyc_drive(1'b0, 24'h0, 1'b1);
    chk("full_sb_empty", exp_q.size(), 0);
    // reset mid-stream with three triples buffered
    for (int i = 0; i < 6; i++) cyc_drive(1'b1, trip(40 + i), 1'b0);
    cyc_drive(1'b0, 24'h0, 1'b0);
    chk("mid_level_pre", 32'(level), 3);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_stall", 32'(bus.stall), 0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_head", {8'h0, bus.a, bus.b, bus.c}, 0);
    chk("mid_rst_stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc_drive(1'b0, 24'h0, 1'b1);
      chk($sformatf("post_rst_rv_c%0d", i), 32'(bus.res_valid), 0);
    end
    // exactly ten stall cycles on one held result
    cyc_drive(1'b1, trip(50), 1'b0);
    n = 0;
    for (int i = 0; i < 20 && n < 10; i++) begin
      cyc_drive(1'b0, 24'h0, 1'b0);
      if (bus.stall) n++;
    end
    chk("stats_stall_seen", n, 10);
    cyc_drive(1'b0, 24'h0, 1'b1);
    chk("stats_stall_released", 32'(bus.stall), 0);
    cyc_drive(1'b0, 24'h0, 1'b1);
`ifdef FEEDER_STATS_EN
    chk("stats_ten", 32'(stall_cycles), 10);
    cyc_drive(1'b1, trip(51), 1'b0);
    repeat (70000) @(negedge clk);
    #1;
    chk("stats_saturate", 32'(stall_cycles), 32'hFFFF);
    cyc_drive(1'b0, 24'h0, 1'b1);
`else
    chk("stats_disabled", 32'(stall_cycles), 0);
`endif
    repeat (6) cyc_drive(1'b0, 24'h0, 1'b1);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e_pipe_feeder.md
# e_pipe_feeder

Operand feeder and flow-control front end for the 3-stage E-pipeline (E = 5A + 5B − 4C + 3D, D fixed at 768).
- Accepts (A, B, C) operand triples on a valid/ready stream and buffers them in a small FIFO.
- Presents one triple (or a bubble) to the pipeline each advancing cycle.
- Tracks per-stage valid bits in a shadow shift register so the pipeline's combinational E output is qualified with a valid flag.
- Generates the pipeline's global stall from downstream backpressure.

## Interface
- DEPTH, 4: FIFO depth in operand triples (power of two, ≥2).
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream triple valid.
- in_ready  out  1  FIFO can accept a triple.
- in_a, in_b, in_c  in  8 each  operands.
- a, b, c  out  8 each  operands driven into pipeline stage 1.
- stall  out  1  global pipeline stall.
- e_in  in  16  E from the pipeline's final combinational stage.
- res_valid  out  1  e_in is a real result.
- res_ready  in  1  downstream accepts result.
- res_data  out  16  equals e_in (pass-through).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- stall_cycles  out  16  stall statistics (see Configuration).

## Operation
- FIFO behaviour:
  - Push when in_valid & in_ready.
  - in_ready = (level != DEPTH); there is no push-when-full, even if a pop occurs in the same cycle.
  - No bypass: a triple pushed into an empty FIFO becomes head on the next cycle.
- Head presentation:
  - a/b/c = FIFO head when level != 0, else 0 (bubble).
  - Pop when ~stall & (level != 0).
  - Push and pop in the same cycle leave level unchanged.
- Shadow valid register vld[2:0]:
  - On each edge with ~stall: vld[0] ← (level != 0), vld[1] ← vld[0], vld[2] ← vld[1].
  - When stall = 1, vld holds, mirroring the pipeline's stage registers.
- Output and stall:
  - res_valid = vld[2].
  - stall = vld[2] & ~res_ready (combinational).
  - Bubbles never stall the pipeline; a bubble at stage 3 with res_ready = 0 does not assert stall.
- Results emerge strictly in push order. No triple is lost or duplicated.
- Arithmetic is done entirely in the pipeline; the feeder does not modify e_in.
- Reset (rst low, any time, including mid-stream):
  - FIFO is emptied and vld is cleared.
  - level = 0, in_ready = 1, stall = 0, res_valid = 0, a = b = c = 0, stall_cycles = 0.
  - All in-flight and buffered triples are discarded. The pipeline shares rst and clears in the same cycle.

## Timing
- Push accepted at edge of cycle t, no stall:
  - head visible in cycle t+1;
  - popped into stage 1 at edge of t+1;
  - res_valid = 1 in cycle t+4.
- Pop to res_valid latency is 3 cycles.
- Sustained throughput: one triple per cycle while res_ready = 1.
- Each stall cycle adds exactly one cycle of latency to every in-flight triple.
- stall responds in the same cycle as res_ready. res_data/res_valid hold while stall = 1.

## Configuration
- FEEDER_STATS_EN:
  - Defined: stall_cycles is a 16-bit counter that increments every cycle in which stall = 1, saturates at 0xFFFF, and clears only on reset.
  - Undefined: stall_cycles is tied to 0 and no counter logic is built.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst = 0 mid-stream with level = 3 → level = 0, in_ready = 1, stall = 0, res_valid = 0, a/b/c = 0; after release, no stale result appears.
- Single op: push A = 1, B = 2, C = 3 in cycle 0 with res_ready = 1 → res_valid = 1 only in cycle 4, res_data = 2307 (0x0903).
- Sparse stream: pushes in cycles 0, 2, 3, 7 → res_valid high in cycles 4, 6, 7, 11, in order, with no stalls.
- Backpressure: res_ready = 0 while pushing 10 back-to-back triples →
  - stall asserts when the first result reaches stage 3;
  - 3 triples are held in the pipeline and 4 in the FIFO, in_ready = 0 with 7 accepted;
  - raising res_ready drains all 7 in order, one per cycle, with no loss.
- Simultaneous push/pop at level = 2 with ~stall → level stays 2 and head advances. Push while full with a pop in progress is refused (in_ready = 0).
- Stats (FEEDER_STATS_EN defined):
  - 10 stall cycles → stall_cycles = 10;
  - force 70000 stall cycles → stall_cycles = 0xFFFF;
  - undefined build → stall_cycles stays 0.
